// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: finds COMMA byte alignment, locks after LOCK_COUNT aligned commas.
// Optional feature macro ALIGN_LOSS_EN: drop lock after LOCK_COUNT periods with misaligned commas.
module serial_paralelo #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
  parameter int              LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             byte_stb
);

  localparam int CW   = $clog2(WIDTH);
  localparam int CNTW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
  localparam logic [CNTW-1:0] LOCK_N = CNTW'(LOCK_COUNT);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t           state, state_next;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    bit_cnt, bit_cnt_next;
  logic [CNTW-1:0]  comma_cnt, comma_cnt_next, comma_inc;
  logic [WIDTH-1:0] data_next, cand;
  logic             valid_next, active_next, stb_next;
  logic             is_comma, boundary;
`ifdef ALIGN_LOSS_EN
  logic [CNTW-1:0]  loss_cnt, loss_next, loss_inc;
  logic             miss, miss_next;
`endif

  // Only the low WIDTH-1 bits of history are ever needed to form the candidate symbol.
  assign cand      = {sr, data_in};
  assign is_comma  = (cand == COMMA);
  assign boundary  = (bit_cnt == LAST);
  assign comma_inc = comma_cnt + 1'b1;
`ifdef ALIGN_LOSS_EN
  assign loss_inc  = loss_cnt + 1'b1;
`endif

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      byte_stb  <= 1'b0;
`ifdef ALIGN_LOSS_EN
      loss_cnt  <= '0;
      miss      <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      sr        <= cand[WIDTH-2:0];
      bit_cnt   <= bit_cnt_next;
      comma_cnt <= comma_cnt_next;
      data_out  <= data_next;
      valid_out <= valid_next;
      active    <= active_next;
      byte_stb  <= stb_next;
`ifdef ALIGN_LOSS_EN
      loss_cnt  <= loss_next;
      miss      <= miss_next;
`endif
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = boundary ? '0 : bit_cnt + 1'b1;
    comma_cnt_next = comma_cnt;
    data_next      = data_out;
    valid_next     = valid_out;
    active_next    = active;
    stb_next       = 1'b0;
`ifdef ALIGN_LOSS_EN
    loss_next      = '0;
    miss_next      = 1'b0;
`endif
    case (state)
      // Bitwise search: a comma at any bit position re-phases the symbol counter.
      HUNT: begin
        valid_next = 1'b0;
        if (is_comma) begin
          bit_cnt_next   = '0;
          comma_cnt_next = CNTW'(1);
          if (LOCK_COUNT == 1) begin
            state_next  = LOCKED;
            active_next = 1'b1;
          end else begin
            state_next = SYNC;
          end
        end
      end
      SYNC: begin
        valid_next = 1'b0;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_next = comma_inc;
            if (comma_inc == LOCK_N) begin
              state_next  = LOCKED;
              active_next = 1'b1;
            end
          end else begin
            state_next     = HUNT;
            comma_cnt_next = '0;
          end
        end
      end
      LOCKED: begin
`ifdef ALIGN_LOSS_EN
        loss_next = loss_cnt;
        miss_next = miss | (is_comma & ~boundary);
`endif
        if (boundary) begin
          data_next  = cand;
          stb_next   = 1'b1;
          valid_next = ~is_comma;
`ifdef ALIGN_LOSS_EN
          // A period counts against the lock only if it held a comma off the boundary.
          miss_next = 1'b0;
          if (is_comma || !miss) begin
            loss_next = '0;
          end else if (loss_inc == LOCK_N) begin
            loss_next      = '0;
            comma_cnt_next = '0;
            state_next     = HUNT;
            active_next    = 1'b0;
            valid_next     = 1'b0;
          end else begin
            loss_next = loss_inc;
          end
`endif
        end
      end
      default: state_next = HUNT;
    endcase
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: directed link scenarios plus random locked traffic,
// checked against a symbol-level model of comma counting and lock behaviour.
module tb_serial_paralelo;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_stb;

  int total = 0;
  int bad   = 0;

  // Symbol-level model: counts consecutive aligned commas until locked, then echoes symbols.
  bit         modelActive;
  int         runCommas;
  logic [7:0] expData;
  bit         expValid;
  bit         expStb;
  logic [7:0] prevSym;

  serial_paralelo #(.WIDTH(8), .COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .byte_stb (byte_stb)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic modelReset();
    modelActive = 0;
    runCommas   = 0;
    expData     = 8'h00;
    expValid    = 0;
    expStb      = 0;
    prevSym     = 8'h00;
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) sendBit(i[0]);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_stb", byte_stb, 0);
    reset = 1'b0;
    modelReset();
  endtask

  // True when the two-symbol stream a,b contains COMMA straddling their boundary.
  function automatic bit misaligned(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    misaligned = 1'b0;
    for (int s = 1; s < 8; s++) begin
      w = {a, b} >> s;
      if (w[7:0] == COMMA) misaligned = 1'b1;
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] sym);
    for (int i = 7; i >= 0; i--) begin
      sendBit(sym[i]);
      if (i == 4) begin
        checkOutput("hold_data", data_out, expData);
        checkOutput("hold_valid", valid_out, expValid);
        checkOutput("hold_stb", byte_stb, 0);
        checkOutput("hold_active", active, modelActive);
      end
    end
    if (modelActive) begin
      expData  = sym;
      expValid = (sym != COMMA);
      expStb   = 1;
    end else begin
      expValid = 0;
      expStb   = 0;
      if (sym == COMMA) runCommas++;
      else runCommas = 0;
      if (runCommas == LOCK_COUNT) modelActive = 1;
    end
    prevSym = sym;
    checkOutput("sym_data", data_out, expData);
    checkOutput("sym_valid", valid_out, expValid);
    checkOutput("sym_stb", byte_stb, expStb);
    checkOutput("sym_active", active, modelActive);
  endtask

`ifdef ALIGN_LOSS_EN
  task automatic sendRaw(input logic [7:0] sym);
    for (int i = 7; i >= 0; i--) sendBit(sym[i]);
  endtask
`endif

  initial begin
    logic [7:0] sym;
    reset   = 1'b1;
    data_in = 1'b0;
    modelReset();
    @(posedge clk_32f);
    #1;

    $display("[TB] reset with toggling input");
    doReset(2);

    $display("[TB] lock on four commas, then data");
    for (int i = 0; i < 4; i++) applyStimulus(COMMA);
    applyStimulus(8'h5A);
    applyStimulus(8'hFF);

    $display("[TB] interrupted comma run does not lock");
    doReset(2);
    for (int i = 0; i < 3; i++) applyStimulus(COMMA);
    applyStimulus(8'h12);
    for (int i = 0; i < 4; i++) applyStimulus(COMMA);
    applyStimulus(8'h33);

    $display("[TB] locked data with an idle comma between");
    applyStimulus(8'hA1);
    applyStimulus(COMMA);
    applyStimulus(8'hB2);

    $display("[TB] random locked traffic");
    for (int n = 0; n < 40; n++) begin
      do begin
        sym = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom_range(0, 255));
      end while (misaligned(prevSym, sym));
      applyStimulus(sym);
    end

    $display("[TB] reset mid-symbol while locked");
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    doReset(1);

    $display("[TB] junk bits before comma stream");
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(COMMA);
    applyStimulus(8'hA7);

`ifdef ALIGN_LOSS_EN
    $display("[TB] slipped bit drops lock, relock on new phase");
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendRaw(COMMA);
    checkOutput("slip_still_active", active, 1);
    sendRaw(COMMA);
    checkOutput("slip_lost", active, 0);
    checkOutput("slip_valid", valid_out, 0);
    for (int i = 0; i < 3; i++) sendRaw(COMMA);
    checkOutput("slip_relock", active, 1);
    modelActive = 1;
    expData     = 8'h5E;
    expValid    = 0;
    prevSym     = COMMA;
    applyStimulus(8'hC5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
